// File: rtl/serial_pattern_tx_pkg.sv
// serial_pattern_tx_pkg: state encoding and the default detection pattern
package serial_pattern_tx_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_GAP = 2'd2;
  localparam logic [6:0] DEFAULT_PATTERN = 7'b1010101;
endpackage

// File: rtl/serial_pattern_tx_bit_shifter.sv
// bit_shifter: parallel-load MSB-first shift register with a bit counter flagging the last bit
module bit_shifter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb,
  output logic             last_bit
);
  localparam int BW = $clog2(WIDTH);
  logic [WIDTH-1:0] sr;
  logic [BW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      cnt <= '0;
    end else if (load) begin
      sr <= din;
      cnt <= '0;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
      cnt <= last_bit ? '0 : cnt + 1'b1;
    end
  assign msb = sr[WIDTH-1];
  assign last_bit = cnt == BW'(WIDTH - 1);
endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: sends a WIDTH-bit frame MSB-first, repeated with an idle gap between frames
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int               WIDTH   = 7,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEFAULT_PATTERN),
  parameter int               GAP     = 2,
  parameter int               CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_pattern,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             ready,
  output logic             out,
  output logic             bit_valid,
  output logic             frame_done
);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  logic [1:0] state;
  logic [WIDTH-1:0] frame, sel;
  logic [CNT_W-1:0] frames_left;
  logic [GW-1:0] gap_cnt;
  logic accept, end_frame, more, gap_end, load, shift, msb, last_bit;
  assign accept = state == ST_IDLE && start;
  assign sel = use_pattern ? PATTERN : data_in;
  assign end_frame = state == ST_SHIFT && last_bit;
  assign more = frames_left != CNT_W'(1);
  assign gap_end = state == ST_GAP && gap_cnt == GW'(GAP - 1);
  // every repeat reloads the shifter from the latched frame, so busy-time input changes never leak in
  assign load = accept || gap_end || (end_frame && more && GAP == 0);
  assign shift = state == ST_SHIFT && !load;
  bit_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk(clk),
    .rst(rst),
    .load(load),
    .shift(shift),
    .din(accept ? sel : frame),
    .msb(msb),
    .last_bit(last_bit)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      frame <= '0;
      frames_left <= '0;
      gap_cnt <= '0;
    end else begin
      if (accept) begin
        frame <= sel;
        frames_left <= repeat_n == '0 ? CNT_W'(1) : repeat_n;
        state <= ST_SHIFT;
      end
      if (end_frame) begin
        frames_left <= frames_left - 1'b1;
        state <= !more ? ST_IDLE : GAP == 0 ? ST_SHIFT : ST_GAP;
        gap_cnt <= '0;
      end
      if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
        if (gap_end) state <= ST_SHIFT;
      end
    end
  assign ready = state == ST_IDLE;
  assign bit_valid = state == ST_SHIFT;
  assign out = bit_valid & msb;
  assign frame_done = end_frame;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed checks of framing, repeats, busy/reset handling and pattern loopback
module tb_serial_pattern_tx;
  logic clk = 0, rst = 1, start = 0, use_pattern = 0;
  logic [6:0] data_in = '0;
  logic [3:0] repeat_n = '0;
  logic ready, out, bit_valid, frame_done;
  logic ready0, out0, bit_valid0, frame_done0;
  logic [6:0] pat = 7'b1010101;
  logic [6:0] word;
  logic [3:0] exp;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  serial_pattern_tx dut (
    .clk(clk), .rst(rst), .start(start), .use_pattern(use_pattern), .data_in(data_in),
    .repeat_n(repeat_n), .ready(ready), .out(out), .bit_valid(bit_valid), .frame_done(frame_done)
  );
  serial_pattern_tx #(.GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .use_pattern(use_pattern), .data_in(data_in),
    .repeat_n(repeat_n), .ready(ready0), .out(out0), .bit_valid(bit_valid0), .frame_done(frame_done0)
  );

  task automatic kick();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out, bit_valid, frame_done, ready} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_state: got {out,bv,fd,rdy}=%b want 0001", {out, bit_valid, frame_done, ready});
    end
    rst = 0;
  endtask

  task automatic test_single();
    use_pattern = 1;
    repeat_n = 0;
    kick();
    for (int i = 0; i < 7; i++) begin
      exp = {pat[6-i], 1'b1, i == 6, 1'b0};
      checks++;
      if ({out, bit_valid, frame_done, ready} !== exp) begin
        fails++;
        $display("FAIL single bit %0d: got %b want %b", i, {out, bit_valid, frame_done, ready}, exp);
      end
      @(negedge clk);
    end
    checks++;
    if ({out, bit_valid, frame_done, ready} !== 4'b0001) begin
      fails++;
      $display("FAIL single_idle: got %b want 0001", {out, bit_valid, frame_done, ready});
    end
  endtask

  task automatic test_custom();
    word = 7'b1100101;
    use_pattern = 0;
    data_in = word;
    repeat_n = 0;
    kick();
    for (int i = 0; i < 7; i++) begin
      exp = {word[6-i], 1'b1, i == 6, 1'b0};
      checks++;
      if ({out, bit_valid, frame_done, ready} !== exp) begin
        fails++;
        $display("FAIL custom bit %0d: got %b want %b", i, {out, bit_valid, frame_done, ready}, exp);
      end
      if (i == 1) begin
        data_in = 7'b0011010;
        use_pattern = 1;
        repeat_n = 5;
      end
      @(negedge clk);
    end
    checks++;
    if ({out, bit_valid, frame_done, ready} !== 4'b0001) begin
      fails++;
      $display("FAIL custom_idle: got %b want 0001", {out, bit_valid, frame_done, ready});
    end
  endtask

  task automatic test_repeat_gap();
    int done_cnt = 0, busy = 0;
    use_pattern = 1;
    repeat_n = 3;
    kick();
    for (int c = 0; c < 25; c++) begin
      exp = (c % 9 < 7) ? {pat[6-(c%9)], 1'b1, (c % 9) == 6, 1'b0} : 4'b0000;
      checks++;
      if ({out, bit_valid, frame_done, ready} !== exp) begin
        fails++;
        $display("FAIL repeat cycle %0d: got %b want %b", c, {out, bit_valid, frame_done, ready}, exp);
      end
      done_cnt += int'(frame_done);
      busy += int'(!ready);
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 3 || busy != 25 || ready !== 1'b1) begin
      fails++;
      $display("FAIL repeat_totals: got done=%0d busy=%0d ready=%b want 3 25 1", done_cnt, busy, ready);
    end
  endtask

  task automatic test_busy_start();
    use_pattern = 1;
    repeat_n = 0;
    kick();
    for (int i = 0; i < 7; i++) begin
      exp = {pat[6-i], 1'b1, i == 6, 1'b0};
      checks++;
      if ({out, bit_valid, frame_done, ready} !== exp) begin
        fails++;
        $display("FAIL busy bit %0d: got %b want %b", i, {out, bit_valid, frame_done, ready}, exp);
      end
      start = (i == 3);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out, bit_valid, frame_done, ready} !== 4'b0001) begin
        fails++;
        $display("FAIL busy_not_queued %0d: got %b want 0001", i, {out, bit_valid, frame_done, ready});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    use_pattern = 1;
    repeat_n = 2;
    kick();
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if ({out, bit_valid, frame_done, ready} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_async: got %b want 0001", {out, bit_valid, frame_done, ready});
    end
    @(negedge clk) rst = 0;
    word = 7'b0110011;
    use_pattern = 0;
    data_in = word;
    repeat_n = 0;
    kick();
    for (int i = 0; i < 7; i++) begin
      exp = {word[6-i], 1'b1, i == 6, 1'b0};
      checks++;
      if ({out, bit_valid, frame_done, ready} !== exp) begin
        fails++;
        $display("FAIL after_reset bit %0d: got %b want %b", i, {out, bit_valid, frame_done, ready}, exp);
      end
      @(negedge clk);
    end
    checks++;
    if ({out, bit_valid, frame_done, ready} !== 4'b0001) begin
      fails++;
      $display("FAIL after_reset_idle: got %b want 0001", {out, bit_valid, frame_done, ready});
    end
  endtask

  task automatic test_loopback();
    logic [6:0] win = '0;
    int det = 0;
    use_pattern = 1;
    repeat_n = 2;
    kick();
    for (int c = 0; c < 14; c++) begin
      exp = {pat[6-(c%7)], 1'b1, (c % 7) == 6, 1'b0};
      checks++;
      if ({out0, bit_valid0, frame_done0, ready0} !== exp) begin
        fails++;
        $display("FAIL loopback cycle %0d: got %b want %b", c, {out0, bit_valid0, frame_done0, ready0}, exp);
      end
      win = {win[5:0], out0};
      if (win == pat) begin
        det++;
        checks++;
        if (frame_done0 !== 1'b1) begin
          fails++;
          $display("FAIL loopback_align cycle %0d: got frame_done=%b want 1", c, frame_done0);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (det != 2 || ready0 !== 1'b1) begin
      fails++;
      $display("FAIL loopback_totals: got det=%0d ready=%b want 2 1", det, ready0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_custom();
    test_repeat_gap();
    test_busy_start();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
